// File: rtl/pll_profile_sequencer.sv
// Filters the requested clock profile and reprograms the system PLL over its reconfiguration
// port, holding the core in reset until the PLL has relocked on the new frequency.
module pll_profile_sequencer #(
    parameter int          STABLE_CYCLES = 4,
    parameter int          LOCK_TIMEOUT  = 1_000_000,
    parameter logic [31:0] M_PAL         = 32'h404,
    parameter logic [31:0] M_NTSC        = 32'h20504,
    parameter logic [31:0] M_BUS         = 32'h404,
    parameter logic [31:0] K_PAL         = 32'd1503512573,
    parameter logic [31:0] K_NTSC        = 32'd3357876127,
    parameter logic [31:0] K_BUS         = 32'd0
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic [1:0]  profile_req,
    input  logic        pll_locked,
    input  logic        cfg_waitrequest,
    output logic        cfg_write,
    output logic [5:0]  cfg_address,
    output logic [31:0] cfg_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  active_profile,
    output logic        hold_reset
);
    localparam int          SW        = $clog2(STABLE_CYCLES + 1);
    localparam logic [19:0] TMO_LIMIT = 20'(LOCK_TIMEOUT);

    typedef enum logic [2:0] {IDLE, W_MODE, W_M, W_K, W_START, WAIT_LOCK} state_t;
    state_t state_q, state_d;
    logic   gap_q, gap_d;

    logic [1:0]    req_sync_p0, req_sync_p1, req_prev;
    logic          lock_sync_p0, lock_sync_p1;
    logic [SW-1:0] stab_cnt;
    logic          req_stable;
    logic [1:0]    req_eff;

    logic [1:0]  tgt;
    logic        applied_valid;
    logic [19:0] tmo_cnt;
    logic        wr_seen_hi, lock_armed;
    logic [5:0]  last_addr, wr_addr;
    logic [31:0] last_data, wr_data;
    logic        start_seq, lock_ok, lock_to, start_wr;

    function automatic logic [31:0] m_word(input logic [1:0] p);
        case (p)
            2'd1:    m_word = M_NTSC;
            2'd2:    m_word = M_BUS;
            default: m_word = M_PAL;
        endcase
    endfunction

    function automatic logic [31:0] k_word(input logic [1:0] p);
        case (p)
            2'd1:    k_word = K_NTSC;
            2'd2:    k_word = K_BUS;
            default: k_word = K_PAL;
        endcase
    endfunction

    // Stage p0/p1: two-flop synchronisers, then the request stability filter
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            req_sync_p0  <= '0;
            req_sync_p1  <= '0;
            req_prev     <= '0;
            lock_sync_p0 <= 1'b0;
            lock_sync_p1 <= 1'b0;
            stab_cnt     <= '0;
        end else begin
            req_sync_p0  <= profile_req;
            req_sync_p1  <= req_sync_p0;
            req_prev     <= req_sync_p1;
            lock_sync_p0 <= pll_locked;
            lock_sync_p1 <= lock_sync_p0;
            if (req_sync_p1 != req_prev)
                stab_cnt <= '0;
            else if (stab_cnt != SW'(STABLE_CYCLES))
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    assign req_stable = (stab_cnt == SW'(STABLE_CYCLES)) && (req_sync_p1 == req_prev);
    assign req_eff    = (req_sync_p1 == 2'd3) ? 2'd0 : req_sync_p1;

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        cfg_write = 1'b0;
        wr_addr   = last_addr;
        wr_data   = last_data;
        start_seq = 1'b0;
        start_wr  = 1'b0;
        lock_ok   = 1'b0;
        lock_to   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_stable && (!applied_valid || req_eff != active_profile)) begin
                    start_seq = 1'b1;
                    gap_d     = 1'b0;
                    state_d   = W_MODE;
                end
            end
            W_MODE: begin
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = W_M;
                end else if (!cfg_waitrequest) begin
                    cfg_write = 1'b1;
                    wr_addr   = 6'd0;
                    wr_data   = 32'd0;
                    gap_d     = 1'b1;
                end
            end
            W_M: begin
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = W_K;
                end else if (!cfg_waitrequest) begin
                    cfg_write = 1'b1;
                    wr_addr   = 6'd4;
                    wr_data   = m_word(tgt);
                    gap_d     = 1'b1;
                end
            end
            W_K: begin
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = W_START;
                end else if (!cfg_waitrequest) begin
                    cfg_write = 1'b1;
                    wr_addr   = 6'd7;
                    wr_data   = k_word(tgt);
                    gap_d     = 1'b1;
                end
            end
            W_START: begin
                // WAIT_LOCK never writes, so it doubles as the gap after the start write
                if (!cfg_waitrequest) begin
                    cfg_write = 1'b1;
                    wr_addr   = 6'd2;
                    wr_data   = 32'd0;
                    start_wr  = 1'b1;
                    state_d   = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_armed && lock_sync_p1) begin
                    lock_ok = 1'b1;
                    state_d = IDLE;
                end else if (tmo_cnt >= TMO_LIMIT) begin
                    lock_to = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_address = wr_addr;
    assign cfg_data    = wr_data;

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state_q        <= IDLE;
            gap_q          <= 1'b0;
            applied_valid  <= 1'b0;
            wr_seen_hi     <= 1'b0;
            lock_armed     <= 1'b0;
            last_addr      <= '0;
            last_data      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            active_profile <= '0;
            hold_reset     <= 1'b1;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            done    <= lock_ok;
            if (cfg_write) begin
                last_addr <= wr_addr;
                last_data <= wr_data;
            end
            if (start_seq) begin
                busy       <= 1'b1;
                hold_reset <= 1'b1;
                error      <= 1'b0;
            end
            // The old lock may still be asserted; only trust it after the PLL has gone busy and back
            if (start_wr) begin
                wr_seen_hi <= 1'b0;
                lock_armed <= 1'b0;
            end else if (state_q == WAIT_LOCK) begin
                if (cfg_waitrequest)
                    wr_seen_hi <= 1'b1;
                else if (wr_seen_hi)
                    lock_armed <= 1'b1;
            end
            if (lock_ok) begin
                active_profile <= tgt;
                applied_valid  <= 1'b1;
                busy           <= 1'b0;
                hold_reset     <= 1'b0;
            end
            if (lock_to) begin
                error         <= 1'b1;
                busy          <= 1'b0;
                hold_reset    <= 1'b0;
                applied_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (start_seq)
            tgt <= req_eff;
        if (start_wr)
            tmo_cnt <= '0;
        else if (tmo_cnt != '1)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pll_profile_sequencer.sv
// Bench for pll_profile_sequencer: directed scenarios plus random profile requests, checked
// against a transaction-level model of the expected register writes and status outputs.
module tb_pll_profile_sequencer;
    localparam int TMO = 300;

    logic        CLK_50M;
    logic        RESET;
    logic [1:0]  profile_req;
    logic        pll_locked;
    logic        cfg_waitrequest;
    logic        cfg_write;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_data;
    logic        busy, done, error, hold_reset;
    logic [1:0]  active_profile;

    pll_profile_sequencer #(.LOCK_TIMEOUT(TMO)) dut (
        .CLK_50M(CLK_50M), .RESET(RESET), .profile_req(profile_req), .pll_locked(pll_locked),
        .cfg_waitrequest(cfg_waitrequest), .cfg_write(cfg_write), .cfg_address(cfg_address),
        .cfg_data(cfg_data), .busy(busy), .done(done), .error(error),
        .active_profile(active_profile), .hold_reset(hold_reset)
    );

    initial CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    logic [31:0] m_tab [3] = '{32'h404, 32'h20504, 32'h404};
    logic [31:0] k_tab [3] = '{32'd1503512573, 32'd3357876127, 32'd0};

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    logic [37:0] wq [$];
    int          wc [$];
    int wr_while_busy = 0;
    int lock_delay = 100, lock_cnt = 0, pll_busy = 0, force_hi = 0;
    bit stall_arm = 0, noise_en = 0;
    logic last_hold = 1'b1, hold_before_done = 1'b0;
    int start_wr_cyc = 0, done_cyc = 0, err_cyc = 0;
    int model_active = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive the mgmt/PLL environment, then observe the DUT mid-cycle
    task automatic tick();
        @(negedge CLK_50M);
        if (force_hi > 0) begin cfg_waitrequest = 1'b1; force_hi--; end
        else if (pll_busy > 0) begin cfg_waitrequest = 1'b1; pll_busy--; end
        else cfg_waitrequest = noise_en && ($urandom_range(0, 3) == 0);
        if (lock_cnt > 0) begin
            lock_cnt--;
            if (lock_cnt == 0) pll_locked = 1'b1;
        end
        #1;
        cyc++;
        if (cfg_write) begin
            wq.push_back({cfg_address, cfg_data});
            wc.push_back(cyc);
            if (cfg_waitrequest) wr_while_busy++;
            if (cfg_address == 6'd0 && stall_arm) begin force_hi = 10; stall_arm = 0; end
            if (cfg_address == 6'd2) begin
                pll_locked   = 1'b0;
                lock_cnt     = lock_delay;
                pll_busy     = 3;
                start_wr_cyc = cyc;
            end
        end
        if (done) begin done_cyc = cyc; hold_before_done = last_hold; end
        if (error) err_cyc = cyc;
        last_hold = hold_reset;
    endtask

    task automatic wait_end(input int budget, output bit got_done, output bit got_err);
        got_done = 0;
        got_err  = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin got_done = 1; break; end
            if (error) begin got_err = 1; break; end
        end
    endtask

    task automatic check_writes(input string tag, input int p);
        logic [5:0]  ea [4];
        logic [31:0] ed [4];
        ea = '{6'd0, 6'd4, 6'd7, 6'd2};
        ed = '{32'd0, m_tab[p], k_tab[p], 32'd0};
        chk({tag, "_nwrites"}, wq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), wq[i][37:32], ea[i]);
                chk($sformatf("%s_data%0d", tag, i), wq[i][31:0], ed[i]);
            end
        end
    endtask

    task automatic clear_log();
        wq.delete();
        wc.delete();
        wr_while_busy = 0;
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit gd, ge, busy_seen;
        int settle, p, e;
        RESET = 1'b1;
        profile_req = 2'd1;
        pll_locked = 1'b0;
        cfg_waitrequest = 1'b0;
        repeat (3) tick();
        chk("rst_cfg_write", cfg_write, 0);
        chk("rst_cfg_address", cfg_address, 0);
        chk("rst_cfg_data", cfg_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_active", active_profile, 0);
        chk("rst_hold_reset", hold_reset, 1);

        // 1: first request after reset, PLL relocks 100 cycles after the start write
        RESET = 1'b0;
        clear_log();
        lock_delay = 100;
        wait_end(500, gd, ge);
        chk("t1_done", gd, 1);
        check_writes("t1", 1);
        chk("t1_active", active_profile, 1);
        chk("t1_hold_at_done", hold_reset, 0);
        chk("t1_hold_before_done", hold_before_done, 1);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_lock_latency_ok", (done_cyc - start_wr_cyc >= 100) && (done_cyc - start_wr_cyc <= 106), 1);
        chk("t1_no_wr_while_busy", wr_while_busy, 0);
        tick();
        chk("t1_done_one_cycle", done, 0);
        model_active = 1;
        clear_log();
        repeat (20) tick();
        chk("t1_idle_no_writes", wq.size(), 0);

        // 2: chattering request is ignored, then settles on Business
        busy_seen = 0;
        for (int i = 0; i < 24; i++) begin
            profile_req = ((i / 2) % 2 == 0) ? 2'd0 : 2'd1;
            tick();
            if (busy) busy_seen = 1;
        end
        chk("t2_toggle_no_writes", wq.size(), 0);
        chk("t2_toggle_not_busy", busy_seen, 0);
        profile_req = 2'd2;
        settle = cyc;
        wait_end(500, gd, ge);
        chk("t2_done", gd, 1);
        check_writes("t2", 2);
        chk("t2_active", active_profile, 2);
        if (wc.size() > 0) chk("t2_filter_delay", (wc[0] - settle) >= 6, 1);
        model_active = 2;

        // 3: mgmt port stalls for 10 cycles before the M-counter write
        clear_log();
        stall_arm = 1;
        lock_delay = 40;
        profile_req = 2'd0;
        wait_end(500, gd, ge);
        chk("t3_done", gd, 1);
        check_writes("t3", 0);
        if (wc.size() >= 2) chk("t3_m_write_cycle", wc[1] - wc[0], 11);
        chk("t3_no_wr_while_busy", wr_while_busy, 0);
        chk("t3_active", active_profile, 0);
        model_active = 0;

        // 4: PLL never relocks -> timeout, then automatic retry
        clear_log();
        lock_delay = 0;
        profile_req = 2'd1;
        wait_end(TMO + 200, gd, ge);
        chk("t4_error", ge, 1);
        chk("t4_no_done", done, 0);
        chk("t4_hold_released", hold_reset, 0);
        chk("t4_timeout_window", (err_cyc - start_wr_cyc >= TMO) && (err_cyc - start_wr_cyc <= TMO + 4), 1);
        lock_delay = 50;
        clear_log();
        tick();
        chk("t4_retry_error_cleared", error, 0);
        chk("t4_retry_busy", busy, 1);
        chk("t4_retry_hold", hold_reset, 1);
        wait_end(500, gd, ge);
        chk("t4_retry_done", gd, 1);
        check_writes("t4r", 1);
        chk("t4_retry_active", active_profile, 1);
        model_active = 1;

        // 5: reset between the M-counter and K writes aborts, then reprograms from scratch
        clear_log();
        lock_delay = 60;
        profile_req = 2'd0;
        for (int i = 0; i < 300 && wq.size() < 2; i++) tick();
        chk("t5_m_written", wq.size() >= 2, 1);
        tick();
        RESET = 1'b1;
        tick();
        chk("t5_abort_no_write", cfg_write, 0);
        chk("t5_abort_hold", hold_reset, 1);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_active", active_profile, 0);
        tick();
        RESET = 1'b0;
        clear_log();
        wait_end(500, gd, ge);
        chk("t5_done", gd, 1);
        check_writes("t5", 0);
        chk("t5_active", active_profile, 0);
        model_active = 0;

        // 6: request changes during WAIT_LOCK; the old sequence finishes first
        clear_log();
        lock_delay = 80;
        profile_req = 2'd1;
        for (int i = 0; i < 300 && wq.size() < 4; i++) tick();
        profile_req = 2'd0;
        wait_end(500, gd, ge);
        chk("t6_first_done", gd, 1);
        check_writes("t6a", 1);
        chk("t6_first_active", active_profile, 1);
        chk("t6_idle_at_done", busy, 0);
        clear_log();
        tick();
        chk("t6_second_start", busy, 1);
        wait_end(500, gd, ge);
        chk("t6_second_done", gd, 1);
        check_writes("t6b", 0);
        chk("t6_second_active", active_profile, 0);
        model_active = 0;

        // Random requests with mgmt-port noise against the transaction model
        noise_en = 1;
        for (int it = 0; it < 10; it++) begin
            p = $urandom_range(0, 3);
            e = (p == 3) ? 0 : p;
            lock_delay = $urandom_range(20, 120);
            stall_arm = ($urandom_range(0, 1) == 1);
            clear_log();
            profile_req = 2'(p);
            if (e != model_active) begin
                wait_end(800, gd, ge);
                chk($sformatf("rnd%0d_done", it), gd, 1);
                check_writes($sformatf("rnd%0d", it), e);
                chk($sformatf("rnd%0d_active", it), active_profile, e);
                chk($sformatf("rnd%0d_no_wr_while_busy", it), wr_while_busy, 0);
                model_active = e;
            end else begin
                stall_arm = 0;
                repeat (30) tick();
                chk($sformatf("rnd%0d_no_writes", it), wq.size(), 0);
                chk($sformatf("rnd%0d_active_kept", it), active_profile, e);
            end
        end
        noise_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
